// File: rtl/vector_op_sequencer.sv
// Vector operation sequencer: issues 1 (scalar) or VLEN (vector) elements to a
// datapath, honouring a stall hold, then pulses done for one cycle and keeps a
// sticky finished flag and the completed-element count until the next start.
module vector_op_sequencer #(
  parameter int N    = 6,
  parameter int VLEN = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_type,
  input  logic         stall,
  output logic         ready,
  output logic         busy,
  output logic         elem_valid,
  output logic [N-1:0] counter,
  output logic         op_type_q,
  output logic         done,
  output logic         finished
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_VLEN = N'(VLEN);

  state_t       state_q, state_d;
  logic [N-1:0] counter_q, counter_d;
  logic         op_type_d;
  logic         finished_q, finished_d;
  logic [N-1:0] limit_s;
  logic         last_elem_s;

  // Element limit of the latched operation and detection of its final element.
  always_comb begin
    limit_s     = CNT_ONE;
    last_elem_s = 1'b0;
    if (op_type_q) begin
      limit_s = CNT_VLEN;
    end else begin
      limit_s = CNT_ONE;
    end
    last_elem_s = (counter_q == (limit_s - CNT_ONE));
  end

  // Next-state, counter, latched op kind and sticky completion flag.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    op_type_d  = op_type_q;
    finished_d = finished_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          counter_d  = CNT_ZERO;
          op_type_d  = op_type;
          finished_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          counter_d = counter_q + CNT_ONE;
          if (last_elem_s) begin
            state_d    = ST_DONE;
            finished_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          counter_d = counter_q;
        end
      end
      ST_DONE: begin
        // Start is ignored here; earliest restart is the following IDLE cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        counter_d  = CNT_ZERO;
        op_type_d  = 1'b0;
        finished_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      counter_q  <= CNT_ZERO;
      op_type_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      op_type_q  <= op_type_d;
      finished_q <= finished_d;
    end
  end

  // Status outputs decoded from the registered state; elem_valid follows stall.
  always_comb begin
    ready      = (state_q == ST_IDLE);
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    elem_valid = (state_q == ST_RUN) && !stall;
    counter    = counter_q;
    finished   = finished_q;
  end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer: a table of scalar/ignore/reset
// vectors, scripted multi-cycle sequences, and randomized traffic compared
// against a transaction-level reference model.
module tb_vector_op_sequencer;

  localparam int N    = 6;
  localparam int VLEN = 20;

  logic         clk = 1'b0;
  logic         rst, start, op_type, stall;
  logic         ready, busy, elem_valid, op_type_q, done, finished;
  logic [N-1:0] counter;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = idle, 1 = issuing elements, 2 = completion cycle.
  int m_phase, m_cnt, m_op, m_fin;
  int busy_seen;

  typedef struct {
    logic s, o, st, r;
    logic e_ready, e_busy, e_done, e_ev;
    int   e_cnt;
    logic e_opq, e_fin;
  } vec_t;

  vector_op_sequencer #(.N(N), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .stall(stall),
    .ready(ready), .busy(busy), .elem_valid(elem_valid), .counter(counter),
    .op_type_q(op_type_q), .done(done), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs with the model (state before the coming edge).
  task automatic check_model();
    chk("ready",      32'(ready),      32'(m_phase == 0));
    chk("busy",       32'(busy),       32'(m_phase == 1));
    chk("done",       32'(done),       32'(m_phase == 2));
    chk("elem_valid", 32'(elem_valid), 32'((m_phase == 1) && !stall));
    chk("counter",    32'(counter),    32'(m_cnt));
    chk("op_type_q",  32'(op_type_q),  32'(m_op));
    chk("finished",   32'(finished),   32'(m_fin));
  endtask

  // Advance the model by one clock according to the sampled inputs.
  task automatic model_step(input logic s, input logic o, input logic st, input logic r);
    int lim;
    lim = (m_op != 0) ? VLEN : 1;
    if (r) begin
      m_phase = 0; m_cnt = 0; m_op = 0; m_fin = 0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1; m_cnt = 0; m_op = int'(o); m_fin = 0;
      end
    end else if (m_phase == 1) begin
      if (!st) begin
        m_cnt++;
        if (m_cnt == lim) begin
          m_phase = 2; m_fin = 1;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // One cycle: drive inputs, check outputs, clock, update model.
  task automatic run_cycle(input logic s, input logic o, input logic st, input logic r);
    start = s; op_type = o; stall = st; rst = r;
    #1;
    check_model();
    if (busy === 1'b1) busy_seen++;
    @(posedge clk);
    model_step(s, o, st, r);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[9];
    int   acc[$];
    int   cyc;

    // Scalar op, ignored start/stall, vector start, reset mid-run.
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0, 1'b0,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, 0, 1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 1, 1'b0,1'b1};
    tbl[3] = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b1};
    tbl[4] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b1};
    tbl[5] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 0, 1'b1,1'b0};
    tbl[6] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b1, 0, 1'b1,1'b0};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1, 1, 1'b1,1'b0};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0, 1'b0,1'b0};

    start = 1'b0; op_type = 1'b0; stall = 1'b0; rst = 1'b1;
    m_phase = 0; m_cnt = 0; m_op = 0; m_fin = 0; busy_seen = 0;
    @(posedge clk);
    @(negedge clk);
    // Reset state, with start/stall asserted to show reset priority.
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].s; op_type = tbl[i].o; stall = tbl[i].st; rst = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(ready),      32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),       32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i),  32'(done),       32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_ev", i),    32'(elem_valid), 32'(tbl[i].e_ev));
      chk($sformatf("tbl%0d_cnt", i),   32'(counter),    32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_opq", i),   32'(op_type_q),  32'(tbl[i].e_opq));
      chk($sformatf("tbl%0d_fin", i),   32'(finished),   32'(tbl[i].e_fin));
      @(posedge clk);
      model_step(tbl[i].s, tbl[i].o, tbl[i].st, tbl[i].r);
      @(negedge clk);
    end

    // Vector with a 3-cycle stall at element 7: 23 RUN cycles, ends at 20.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    busy_seen = 0;
    for (int i = 0; i < 23; i++) begin
      if (i >= 7 && i < 10) begin
        chk("stall_hold_cnt", 32'(counter), 32'd7);
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      end else begin
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("stall_run_cycles", 32'(busy_seen), 32'd23);
    chk("stall_done",  32'(done),     32'd1);
    chk("stall_final", 32'(counter),  32'd20);
    chk("stall_fin",   32'(finished), 32'd1);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_hold_cnt", 32'(counter), 32'd20);

    // Reset at counter 12, then a full 20-element run.
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(counter), 32'd12);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_cnt",   32'(counter),  32'd0);
    chk("post_rst_fin",   32'(finished), 32'd0);
    chk("post_rst_ready", 32'(ready),    32'd1);
    run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_run_cycles", 32'(busy_seen), 32'd20);
    chk("full_run_cnt",    32'(counter),   32'd20);
    run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high: acceptances 22 cycles apart.
    for (int i = 0; i < 70; i++) begin
      if (ready === 1'b1) acc.push_back(i);
      run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("b2b_count", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_gap", 32'(acc[i] - acc[i-1]), 32'd22);
    // Let any running op finish before randomized traffic.
    for (int i = 0; i < 25; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    cyc = 0;
    repeat (3000) begin
      run_cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
